pulse_sequencer: RTL and testbench
==================================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 The block SHALL have parameter CW, default 16, meaning the width of the duration fields and counters, in clock cycles.
REQ-002 The block SHALL have parameter VW, default 12, meaning the width of the signed level and step values.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a 1-cycle request to begin a pulse train.
REQ-006 The block SHALL have port stop, input, 1 bit: a 1-cycle request to abort the train.
REQ-007 The block SHALL have ports td, tr, th, tf, tl, each input, CW bits: the delay, rise, high, fall and low durations.
REQ-008 The block SHALL have ports iv and pv, each input, VW bits, signed: the initial/low level and the pulse level.
REQ-009 The block SHALL have ports rstep and fstep, each input, VW bits, signed: the per-cycle level increment during rise and during fall.
REQ-010 The block SHALL have port cycles, input, CW bits: the number of periods to run, where 0 means run forever.
REQ-011 The block SHALL have port level, output, VW bits, signed: the sequenced source value.
REQ-012 The block SHALL have port phase, output, 3 bits: the current state encoding.
REQ-013 The block SHALL have ports busy, period_tick and done, each output, 1 bit: train active, a 1-cycle end-of-period pulse, and a 1-cycle train-complete pulse.

Function
REQ-014 The block SHALL implement states with phase encodings IDLE=0, DELAY=1, RISE=2, HIGH=3, FALL=4, LOW=5.
REQ-015 The block SHALL latch all configuration inputs when start is accepted and SHALL ignore configuration changes until the block is next in IDLE.
REQ-016 The block SHALL accept start only in IDLE; a start while busy=1 SHALL be ignored.
REQ-017 A start accepted in cycle k SHALL put the block in its first non-skipped state at cycle k+1, with busy=1 from cycle k+1.
REQ-018 Each of DELAY, RISE, HIGH, FALL and LOW SHALL last exactly its latched duration in cycles.
REQ-019 A DELAY, RISE, FALL or LOW duration of 0 SHALL skip that state with no idle cycle.
REQ-020 A th of 0 SHALL be treated as 1 cycle, so a period is never shorter than 1 cycle.
REQ-021 The state order SHALL be DELAY -> RISE -> HIGH -> FALL -> LOW, with DELAY entered only once per train.
REQ-022 Level in IDLE, DELAY and LOW SHALL equal iv.
REQ-023 Level in HIGH SHALL equal pv.
REQ-024 In RISE, level SHALL be iv on the first RISE cycle and then increase by rstep each cycle, saturating at the signed VW-bit range; level SHALL equal exactly pv on the first HIGH cycle regardless of the accumulated value.
REQ-025 In FALL, level SHALL be pv on the first FALL cycle and then increase by fstep each cycle, with the same saturation; level SHALL equal exactly iv on the first LOW cycle (or on the following state if LOW is skipped).
REQ-026 At the end of the last cycle of LOW (or of FALL or HIGH when later states are skipped), period_tick SHALL pulse for 1 cycle and an internal period count SHALL increment.
REQ-027 If cycles is nonzero and the period count reaches cycles, the block SHALL go to IDLE next cycle, pulse done for 1 cycle coincident with the IDLE entry, and drop busy.
REQ-028 Otherwise the block SHALL return to RISE (or the first non-skipped state after DELAY).
REQ-029 The period count SHALL wrap silently when cycles=0.
REQ-030 stop SHALL take effect the next cycle from any non-IDLE state: IDLE, level=iv, busy=0, with no done pulse.
REQ-031 stop SHALL take precedence over a simultaneous period end.
REQ-032 stop and start asserted together in IDLE SHALL be treated as no start.
REQ-033 All outputs SHALL be registered, and RISE and FALL durations SHALL be counted with CW-bit down-counters.

Reset
REQ-034 While rst_n=0, the block SHALL asynchronously force state IDLE, phase=0, level=0, busy=0, period_tick=0, done=0, all counters 0 and latched configuration 0.
REQ-035 After rst_n is released, outputs SHALL hold their reset values until the first accepted start.
REQ-036 A reset during an active train SHALL abort it with no done pulse.

Verification
REQ-037 The bench SHALL check: td=2, tr=4, th=3, tf=4, tl=5, iv=0, pv=100, rstep=25, fstep=-25, cycles=2, start -> phases 1x2, 2x4, 3x3, 4x4, 5x5, then 2x4, 3x3, 4x4, 5x5; rise levels 0,25,50,75 then 100; period_tick twice; done once; busy low afterwards.
REQ-038 The bench SHALL check: tr=tf=tl=td=0, th=0, cycles=3 -> phase stays 3 for 3 cycles, period_tick every cycle, done at cycle 4.
REQ-039 The bench SHALL check: cycles=0 with stop asserted in HIGH of period 7 -> IDLE next cycle, level=iv, no done.
REQ-040 The bench SHALL check: rstep=2000 with VW=12, iv=0, pv=1000, tr=3 -> saturation at 2047, then exactly 1000 on entry to HIGH.
REQ-041 The bench SHALL check: a second start mid-train and configuration changes mid-train -> no effect on the sequence.
REQ-042 The bench SHALL check: rst_n pulsed low mid-FALL, asynchronously to clk -> all outputs zero immediately; a new start afterwards behaves as in REQ-037.

Source files
------------

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - pulse train level sequencer (delay/rise/high/fall/low)
//
// Generates a trapezoidal pulse train on `level`. A train starts with an
// optional DELAY, then repeats RISE -> HIGH -> FALL -> LOW periods until
// `cycles` periods have completed (or forever when cycles == 0).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, stop         1-cycle train start request / abort request
//   td,tr,th,tf,tl      delay/rise/high/fall/low durations in cycles
//   iv, pv              initial (low) level and pulse level, signed
//   rstep, fstep        per-cycle level increment in RISE / FALL, signed
//   cycles              periods per train, 0 = run forever
//   level               sequenced level, signed, registered
//   phase               state encoding (IDLE=0 .. LOW=5), registered
//   busy                train active
//   period_tick         1-cycle pulse in the cycle after each period end
//   done                1-cycle pulse on IDLE entry after the last period
module pulse_sequencer #(
    parameter int CW = 16,
    parameter int VW = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CW-1:0]        td,
    input  logic [CW-1:0]        tr,
    input  logic [CW-1:0]        th,
    input  logic [CW-1:0]        tf,
    input  logic [CW-1:0]        tl,
    input  logic signed [VW-1:0] iv,
    input  logic signed [VW-1:0] pv,
    input  logic signed [VW-1:0] rstep,
    input  logic signed [VW-1:0] fstep,
    input  logic [CW-1:0]        cycles,
    output logic signed [VW-1:0] level,
    output logic [2:0]           phase,
    output logic                 busy,
    output logic                 period_tick,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_RISE  = 3'd2,
        S_HIGH  = 3'd3,
        S_FALL  = 3'd4,
        S_LOW   = 3'd5
    } state_t;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;      // cycles remaining after the current one
    logic [CW-1:0]        pcnt_q, pcnt_d;    // completed periods
    logic signed [VW-1:0] level_q, level_d;
    logic                 busy_q, busy_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;

    logic [CW-1:0]        td_q, td_d, tr_q, tr_d, th_q, th_d;
    logic [CW-1:0]        tf_q, tf_d, tl_q, tl_d, cycles_q, cycles_d;
    logic signed [VW-1:0] iv_q, iv_d, pv_q, pv_d;
    logic signed [VW-1:0] rstep_q, rstep_d, fstep_q, fstep_d;

    state_t               nxt;
    state_t               fps;     // first state of each period
    logic                 enter;   // a state (re)entry happens at the next edge
    logic                 pend;    // current cycle is the last one of a period

    function automatic logic signed [VW-1:0] sat_add(input logic signed [VW-1:0] a,
                                                     input logic signed [VW-1:0] b);
        logic signed [VW:0] s;
        s = {a[VW-1], a} + {b[VW-1], b};
        if (s[VW] != s[VW-1]) begin
            sat_add = s[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
        end else begin
            sat_add = s[VW-1:0];
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        level_d  = level_q;
        busy_d   = busy_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        td_d     = td_q;
        tr_d     = tr_q;
        th_d     = th_q;
        tf_d     = tf_q;
        tl_d     = tl_q;
        cycles_d = cycles_q;
        iv_d     = iv_q;
        pv_d     = pv_q;
        rstep_d  = rstep_q;
        fstep_d  = fstep_q;
        enter    = 1'b0;
        pend     = 1'b0;
        nxt      = state_q;

        if (state_q == S_IDLE && start && !stop) begin
            td_d     = td;
            tr_d     = tr;
            th_d     = th;
            tf_d     = tf;
            tl_d     = tl;
            cycles_d = cycles;
            iv_d     = iv;
            pv_d     = pv;
            rstep_d  = rstep;
            fstep_d  = fstep;
        end

        // Durations below come from the _d copies so that the start cycle
        // already sees the freshly latched configuration.
        fps = (tr_d != '0) ? S_RISE : S_HIGH;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    pcnt_d = '0;
                    busy_d = 1'b1;
                    enter  = 1'b1;
                    nxt    = (td != '0) ? S_DELAY : fps;
                end
            end
            default: begin
                if (stop) begin
                    enter  = 1'b1;
                    nxt    = S_IDLE;
                    busy_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                    if (state_q == S_RISE) begin
                        level_d = sat_add(level_q, rstep_q);
                    end else if (state_q == S_FALL) begin
                        level_d = sat_add(level_q, fstep_q);
                    end
                end else begin
                    enter = 1'b1;
                    case (state_q)
                        S_DELAY: nxt = fps;
                        S_RISE:  nxt = S_HIGH;
                        S_HIGH: begin
                            if (tf_q != '0)      nxt = S_FALL;
                            else if (tl_q != '0) nxt = S_LOW;
                            else                 pend = 1'b1;
                        end
                        S_FALL: begin
                            if (tl_q != '0) nxt = S_LOW;
                            else            pend = 1'b1;
                        end
                        default: pend = 1'b1;
                    endcase
                    if (pend) begin
                        pcnt_d = pcnt_q + ONE;
                        tick_d = 1'b1;
                        if (cycles_q != '0 && pcnt_d == cycles_q) begin
                            nxt    = S_IDLE;
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end else begin
                            nxt = fps;
                        end
                    end
                end
            end
        endcase

        // On entry: load the state's down-counter and snap the level to the
        // state's starting value (this discards any saturated ramp residue).
        if (enter) begin
            state_d = nxt;
            case (nxt)
                S_DELAY: begin cnt_d = td_d - ONE; level_d = iv_d; end
                S_RISE:  begin cnt_d = tr_d - ONE; level_d = iv_d; end
                S_HIGH:  begin cnt_d = (th_d == '0) ? '0 : th_d - ONE; level_d = pv_d; end
                S_FALL:  begin cnt_d = tf_d - ONE; level_d = pv_d; end
                S_LOW:   begin cnt_d = tl_d - ONE; level_d = iv_d; end
                default: begin cnt_d = '0; level_d = iv_d; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            td_q     <= '0;
            tr_q     <= '0;
            th_q     <= '0;
            tf_q     <= '0;
            tl_q     <= '0;
            cycles_q <= '0;
            iv_q     <= '0;
            pv_q     <= '0;
            rstep_q  <= '0;
            fstep_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            td_q     <= td_d;
            tr_q     <= tr_d;
            th_q     <= th_d;
            tf_q     <= tf_d;
            tl_q     <= tl_d;
            cycles_q <= cycles_d;
            iv_q     <= iv_d;
            pv_q     <= pv_d;
            rstep_q  <= rstep_d;
            fstep_q  <= fstep_d;
        end
    end

    assign level       = level_q;
    assign phase       = state_q;
    assign busy        = busy_q;
    assign period_tick = tick_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - directed self-checking bench for pulse_sequencer
module tb_pulse_sequencer;
    localparam int CW = 16;
    localparam int VW = 12;

    logic                 clk, rst_n, start, stop;
    logic [CW-1:0]        td, tr, th, tf, tl, cycles;
    logic signed [VW-1:0] iv, pv, rstep, fstep;
    logic signed [VW-1:0] level;
    logic [2:0]           phase;
    logic                 busy, period_tick, done;

    int checks   = 0;
    int failures = 0;

    pulse_sequencer #(.CW(CW), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .td(td), .tr(tr), .th(th), .tf(tf), .tl(tl),
        .iv(iv), .pv(pv), .rstep(rstep), .fstep(fstep), .cycles(cycles),
        .level(level), .phase(phase), .busy(busy),
        .period_tick(period_tick), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int d, input int r, input int h, input int f, input int l,
                           input int i, input int p, input int rs, input int fs, input int c);
        td = CW'(d); tr = CW'(r); th = CW'(h); tf = CW'(f); tl = CW'(l);
        iv = VW'(i); pv = VW'(p); rstep = VW'(rs); fstep = VW'(fs); cycles = CW'(c);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_phase(input logic [2:0] p, input string tag);
        int n = 0;
        while (phase !== p && n < 200) begin
            cyc();
            n++;
        end
        chk(tag, phase, p);
    endtask

    task automatic chk_idle(input string tag, input int lvl, input int dn, input int tk);
        chk({tag, " phase"}, phase, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " level"}, level, lvl);
        chk({tag, " done"}, done, dn);
        chk({tag, " tick"}, period_tick, tk);
    endtask

    // Two-period reference train; with disturb set, a second start and new
    // configuration values are applied mid-train and must change nothing.
    task automatic train37(input bit disturb, input string tag);
        int sp [9] = '{1, 2, 3, 4, 5, 2, 3, 4, 5};
        int sn [9] = '{2, 4, 3, 4, 5, 4, 3, 4, 5};
        int sl [9] = '{0, 0, 100, 100, 0, 0, 100, 100, 0};
        int ss [9] = '{0, 25, 0, -25, 0, 25, 0, -25, 0};
        int eph[$];
        int elv[$];
        for (int s = 0; s < 9; s++) begin
            for (int j = 0; j < sn[s]; j++) begin
                eph.push_back(sp[s]);
                elv.push_back(sl[s] + j * ss[s]);
            end
        end
        set_cfg(2, 4, 3, 4, 5, 0, 100, 25, -25, 2);
        pulse_start();
        for (int i = 0; i < 34; i++) begin
            chk($sformatf("%s phase[%0d]", tag, i), phase, eph[i]);
            chk($sformatf("%s level[%0d]", tag, i), level, elv[i]);
            chk($sformatf("%s busy[%0d]", tag, i), busy, 1);
            chk($sformatf("%s tick[%0d]", tag, i), period_tick, (i == 18) ? 1 : 0);
            chk($sformatf("%s done[%0d]", tag, i), done, 0);
            if (disturb && i == 10) begin
                start = 1'b1;
                set_cfg(7, 1, 1, 1, 1, -9, 555, 3, 3, 9);
            end
            if (disturb && i == 11) start = 1'b0;
            cyc();
        end
        chk_idle({tag, " end"}, 0, 1, 1);
        cyc();
        chk_idle({tag, " after"}, 0, 0, 0);
    endtask

    initial begin
        int ticks;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        set_cfg(3, 3, 3, 3, 3, 33, 44, 1, 1, 1);
        #12;
        chk_idle("reset", 0, 0, 0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk_idle("post reset hold", 0, 0, 0);

        // start with stop in IDLE is no start
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("start+stop", 0, 0, 0);

        train37(1'b0, "t37");

        // all durations zero, th=0 acts as one cycle
        set_cfg(0, 0, 0, 0, 0, 7, 9, 0, 0, 3);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t38 phase[%0d]", i), phase, 3);
            chk($sformatf("t38 level[%0d]", i), level, 9);
            chk($sformatf("t38 tick[%0d]", i), period_tick, (i == 0) ? 0 : 1);
            chk($sformatf("t38 done[%0d]", i), done, 0);
            cyc();
        end
        chk_idle("t38 end", 7, 1, 1);

        // stop on the last cycle of the final period wins over done
        set_cfg(0, 0, 0, 0, 0, 7, 9, 0, 0, 1);
        pulse_start();
        chk("t31 high", phase, 3);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_idle("t31 stop", 7, 0, 0);

        // free-running train, stop in HIGH of period 7
        set_cfg(0, 1, 2, 1, 1, -50, 300, 10, -10, 0);
        pulse_start();
        ticks = 0;
        n = 0;
        while (ticks < 6 && n < 100) begin
            if (period_tick === 1'b1) ticks++;
            if (ticks < 6) begin
                cyc();
                n++;
            end
        end
        chk("t39 ticks", ticks, 6);
        chk("t39 p7 rise", phase, 2);
        chk("t39 busy", busy, 1);
        wait_phase(3, "t39 reach high");
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_idle("t39 stop", -50, 0, 0);
        cyc();
        chk_idle("t39 after", -50, 0, 0);

        // rise saturation then exact pv on HIGH entry
        set_cfg(0, 3, 1, 0, 0, 0, 1000, 2000, 0, 1);
        pulse_start();
        chk("t40 rise0 phase", phase, 2);
        chk("t40 rise0 level", level, 0);
        cyc();
        chk("t40 rise1 level", level, 2000);
        cyc();
        chk("t40 rise2 level", level, 2047);
        cyc();
        chk("t40 high phase", phase, 3);
        chk("t40 high level", level, 1000);
        cyc();
        chk_idle("t40 end", 0, 1, 1);

        train37(1'b1, "t41");

        // asynchronous reset in FALL
        set_cfg(2, 4, 3, 4, 5, 0, 100, 25, -25, 2);
        pulse_start();
        wait_phase(4, "t42 reach fall");
        cyc();
        chk("t42 fall level", level, 75);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("t42 async", 0, 0, 0);
        @(posedge clk);
        #1;
        chk_idle("t42 held", 0, 0, 0);
        #2;
        rst_n = 1'b1;
        cyc();
        chk_idle("t42 released", 0, 0, 0);
        train37(1'b0, "t42 rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
